// File: rtl/snax_csr_req_ctrl.sv
// snax_csr_req_ctrl
// Bridges the Snitch core CSR request/response port to one SNAX accelerator
// CSR port. Addresses CsrBegin..CsrEnd are claimed and rebased to accelerator
// offsets. Other addresses are answered locally with an error. A small
// tracking FIFO of response kinds returns responses strictly in request order.
// Optional feature: define SNAX_CSR_REQ_CTRL_STATS_EN to add the saturating
// request counters stat_rd_o, stat_wr_o and stat_err_o.
module snax_csr_req_ctrl #(
    parameter logic [11:0] CsrBegin       = 12'h3c0,
    parameter logic [11:0] CsrEnd         = 12'h5ff,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned NumOutstanding = 4,
    parameter int unsigned AccAddrWidth   = $clog2(CsrEnd - CsrBegin + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [11:0]             req_addr_i,
    input  logic [DataWidth-1:0]    req_data_i,
    input  logic                    req_write_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    output logic [DataWidth-1:0]    rsp_data_o,
    output logic                    rsp_err_o,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [AccAddrWidth-1:0] acc_req_addr_o,
    output logic [DataWidth-1:0]    acc_req_data_o,
    output logic                    acc_req_write_o,
    output logic                    acc_req_valid_o,
    input  logic                    acc_req_ready_i,
    input  logic [DataWidth-1:0]    acc_rsp_data_i,
    input  logic                    acc_rsp_valid_i,
`ifdef SNAX_CSR_REQ_CTRL_STATS_EN
    output logic [31:0]             stat_rd_o,
    output logic [31:0]             stat_wr_o,
    output logic [31:0]             stat_err_o,
`endif
    output logic                    acc_rsp_ready_o
);

    localparam int unsigned PtrWidth = $clog2(NumOutstanding);
    localparam int unsigned CntWidth = $clog2(NumOutstanding + 1);

    // What the response for a tracked request must look like.
    typedef enum logic [1:0] {
        KIND_ACC_RD  = 2'd0,
        KIND_LOC_OK  = 2'd1,
        KIND_LOC_ERR = 2'd2
    } kind_e;

    logic [PtrWidth-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PtrWidth-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CntWidth-1:0] count_reg, count_next;

    logic [NumOutstanding-1:0][1:0] kind_flat;

    logic  in_win;
    logic  full;
    logic  push;
    logic  pop;
    kind_e push_kind;
    kind_e head_kind;

    // Request side: window decode, rebasing and handshake.
    assign in_win          = (req_addr_i >= CsrBegin) && (req_addr_i <= CsrEnd);
    assign full            = (count_reg == CntWidth'(NumOutstanding));
    assign acc_req_addr_o  = AccAddrWidth'(req_addr_i - CsrBegin);
    assign acc_req_data_o  = req_data_i;
    assign acc_req_write_o = req_write_i;
    assign acc_req_valid_o = req_valid_i && in_win && !full;
    assign req_ready_o     = !full && (!in_win || acc_req_ready_i);
    assign push            = req_valid_i && req_ready_o;

    // Classify the incoming request into its response kind.
    always_comb begin
        push_kind = KIND_LOC_ERR;
        if (in_win) begin
            push_kind = req_write_i ? KIND_LOC_OK : KIND_ACC_RD;
        end
    end

    // One kind slot per FIFO entry, written when the write pointer selects it.
    genvar gi;
    generate
        for (gi = 0; gi < NumOutstanding; gi++) begin : g_entry
            logic [1:0] kind_reg;

            // Capture the kind of an accepted request into this slot.
            always_ff @(posedge clk_i) begin
                if (push && (wr_ptr_reg == PtrWidth'(gi))) begin
                    kind_reg <= push_kind;
                end
            end

            assign kind_flat[gi] = kind_reg;
        end
    endgenerate

    assign head_kind = kind_e'(kind_flat[rd_ptr_reg]);

    // Response side: serve the head entry; accelerator reads pass straight through.
    always_comb begin
        rsp_valid_o     = 1'b0;
        rsp_err_o       = 1'b0;
        rsp_data_o      = '0;
        acc_rsp_ready_o = 1'b0;
        pop             = 1'b0;
        if (count_reg != '0) begin
            case (head_kind)
                KIND_ACC_RD: begin
                    rsp_valid_o     = acc_rsp_valid_i;
                    rsp_data_o      = acc_rsp_data_i;
                    acc_rsp_ready_o = rsp_ready_i;
                    pop             = acc_rsp_valid_i && rsp_ready_i;
                end
                KIND_LOC_OK: begin
                    rsp_valid_o = 1'b1;
                    pop         = rsp_ready_i;
                end
                KIND_LOC_ERR: begin
                    rsp_valid_o = 1'b1;
                    rsp_err_o   = 1'b1;
                    pop         = rsp_ready_i;
                end
                default: begin
                    rsp_valid_o = 1'b0;
                end
            endcase
        end
    end

    // Pointer and occupancy update; power-of-two depth makes pointers wrap naturally.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PtrWidth'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PtrWidth'(1);
        end
        if (push && !pop) begin
            count_next = count_reg + CntWidth'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CntWidth'(1);
        end
    end

    // FIFO control registers; reset drops every tracked entry.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

`ifdef SNAX_CSR_REQ_CTRL_STATS_EN
    logic [31:0] stat_rd_reg;
    logic [31:0] stat_wr_reg;
    logic [31:0] stat_err_reg;

    // Saturating counters of accepted reads, writes and out-of-window accesses.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stat_rd_reg  <= '0;
            stat_wr_reg  <= '0;
            stat_err_reg <= '0;
        end else if (push) begin
            if ((push_kind == KIND_ACC_RD) && (stat_rd_reg != '1)) begin
                stat_rd_reg <= stat_rd_reg + 32'd1;
            end
            if ((push_kind == KIND_LOC_OK) && (stat_wr_reg != '1)) begin
                stat_wr_reg <= stat_wr_reg + 32'd1;
            end
            if ((push_kind == KIND_LOC_ERR) && (stat_err_reg != '1)) begin
                stat_err_reg <= stat_err_reg + 32'd1;
            end
        end
    end

    assign stat_rd_o  = stat_rd_reg;
    assign stat_wr_o  = stat_wr_reg;
    assign stat_err_o = stat_err_reg;
`endif

endmodule
